// File: rtl/johnson_seq_monitor.sv
// Consumer-side checker for a 4-bit Johnson ring counter: decodes the code to a
// phase, flags illegal codes and steps, counts revolutions and error cycles.
module johnson_seq_monitor #(
    parameter int REV_W      = 8,
    parameter int ERR_W      = 4,
    parameter int ALLOW_HOLD = 0
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic [3:0]       i_q,
    input  logic             i_up_srst,
    input  logic             i_clr,
    output logic [2:0]       o_phase,
    output logic             o_valid,
    output logic             o_wrap,
    output logic [REV_W-1:0] o_revs,
    output logic             o_err_code,
    output logic             o_err_step,
    output logic             o_err_sticky,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       code_ok;
    logic [2:0] code_phase;
    logic [2:0] phase_inc;
    logic       step_ok;
    logic [2:0] phase_next;
    logic       valid_next;
    logic       wrap_next;
    logic       err_code_next;
    logic       err_step_next;
    logic       err_any;

    always_comb begin
        code_ok    = 1'b1;
        code_phase = 3'd0;
        case (i_q)
            4'b0000: code_phase = 3'd0;
            4'b0001: code_phase = 3'd1;
            4'b0011: code_phase = 3'd2;
            4'b0111: code_phase = 3'd3;
            4'b1111: code_phase = 3'd4;
            4'b1110: code_phase = 3'd5;
            4'b1100: code_phase = 3'd6;
            4'b1000: code_phase = 3'd7;
            default: code_ok = 1'b0;
        endcase
    end

    // The 3-bit increment wraps 7 -> 0 on its own, which is exactly the ring order.
    assign phase_inc = o_phase + 3'd1;
    assign step_ok   = (code_phase == phase_inc) ||
                       ((ALLOW_HOLD != 0) && (code_phase == o_phase));

    always_comb begin
        state_next    = state;
        phase_next    = o_phase;
        valid_next    = 1'b0;
        wrap_next     = 1'b0;
        err_code_next = 1'b0;
        err_step_next = 1'b0;
        if (!i_up_srst) begin
            // Upstream drains through junk codes while in reset; stay silent and re-acquire.
            state_next = ACQUIRE;
        end else begin
            case (state)
                ACQUIRE, FAULT: begin
                    if (code_ok) begin
                        phase_next = code_phase;
                        state_next = TRACK;
                    end else begin
                        err_code_next = 1'b1;
                    end
                end
                TRACK: begin
                    if (!code_ok) begin
                        err_code_next = 1'b1;
                        state_next    = FAULT;
                    end else if (step_ok) begin
                        valid_next = 1'b1;
                        wrap_next  = (o_phase == 3'd7) && (code_phase == 3'd0);
                        phase_next = code_phase;
                    end else begin
                        err_step_next = 1'b1;
                        phase_next    = code_phase;
                        state_next    = FAULT;
                    end
                end
                default: state_next = ACQUIRE;
            endcase
        end
    end

    assign err_any = err_code_next | err_step_next;
    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= ACQUIRE;
        end else begin
            state <= state_next;
        end
    end

    // o_valid qualifies o_phase for downstream logging; there is no back-pressure.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_phase      <= 3'd0;
            o_valid      <= 1'b0;
            o_wrap       <= 1'b0;
            o_err_code   <= 1'b0;
            o_err_step   <= 1'b0;
            o_revs       <= '0;
            o_err_cnt    <= '0;
            o_err_sticky <= 1'b0;
        end else begin
            o_phase    <= phase_next;
            o_valid    <= valid_next;
            o_wrap     <= wrap_next;
            o_err_code <= err_code_next;
            o_err_step <= err_step_next;
            if (i_clr) begin
                o_revs       <= '0;
                o_err_cnt    <= '0;
                o_err_sticky <= 1'b0;
            end else begin
                if (wrap_next && (o_revs != '1)) begin
                    o_revs <= o_revs + REV_W'(1);
                end
                if (err_any) begin
                    o_err_sticky <= 1'b1;
                    if (o_err_cnt != '1) begin
                        o_err_cnt <= o_err_cnt + ERR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Bench for johnson_seq_monitor: two instances (hold disallowed / allowed) share
// stimulus and are compared every cycle with a phase-arithmetic reference model.
module tb_johnson_seq_monitor;

    localparam int REV_MAX = 255;
    localparam int ERR_MAX = 15;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] q = 4'h0;
    logic       srst = 1'b1;
    logic       clr = 1'b0;

    logic [2:0] n_phase, h_phase;
    logic       n_valid, h_valid, n_wrap, h_wrap;
    logic [7:0] n_revs, h_revs;
    logic       n_ec, h_ec, n_es, h_es, n_st, h_st;
    logic [3:0] n_cnt, h_cnt;
    logic [1:0] n_state, h_state;

    johnson_seq_monitor #(.REV_W(8), .ERR_W(4), .ALLOW_HOLD(0)) dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_q(q), .i_up_srst(srst), .i_clr(clr),
        .o_phase(n_phase), .o_valid(n_valid), .o_wrap(n_wrap), .o_revs(n_revs),
        .o_err_code(n_ec), .o_err_step(n_es), .o_err_sticky(n_st),
        .o_err_cnt(n_cnt), .o_state(n_state)
    );

    johnson_seq_monitor #(.REV_W(8), .ERR_W(4), .ALLOW_HOLD(1)) dut_hold (
        .i_clk(clk), .i_arst_n(rst_n), .i_q(q), .i_up_srst(srst), .i_clr(clr),
        .o_phase(h_phase), .o_valid(h_valid), .o_wrap(h_wrap), .o_revs(h_revs),
        .o_err_code(h_ec), .o_err_step(h_es), .o_err_sticky(h_st),
        .o_err_cnt(h_cnt), .o_state(h_state)
    );

    wire [21:0] obs_n = {n_state, n_phase, n_valid, n_wrap, n_revs, n_ec, n_es, n_st, n_cnt};
    wire [21:0] obs_h = {h_state, h_phase, h_valid, h_wrap, h_revs, h_ec, h_es, h_st, h_cnt};

    int checks = 0;
    int failures = 0;
    int up_k = 0;

    logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    // reference model: mode 0 = acquire, 1 = track, 2 = fault; index 1 allows holds
    int m_mode [2];
    int m_phase [2];
    int m_revs [2];
    int m_cnt [2];
    bit m_valid [2];
    bit m_wrap [2];
    bit m_ec [2];
    bit m_es [2];
    bit m_st [2];

    logic [43:0] exp_q [$];

    function automatic int find_phase(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            m_mode[h] = 0; m_phase[h] = 0; m_revs[h] = 0; m_cnt[h] = 0;
            m_valid[h] = 0; m_wrap[h] = 0; m_ec[h] = 0; m_es[h] = 0; m_st[h] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] c, input logic s, input logic cl);
        int p;
        p = find_phase(c);
        for (int h = 0; h < 2; h++) begin
            m_valid[h] = 0; m_wrap[h] = 0; m_ec[h] = 0; m_es[h] = 0;
            if (!s) begin
                m_mode[h] = 0;
            end else if (m_mode[h] == 1) begin
                if (p < 0) begin
                    m_ec[h] = 1; m_mode[h] = 2;
                end else if (p == (m_phase[h] + 1) % 8 || (h == 1 && p == m_phase[h])) begin
                    m_valid[h] = 1;
                    m_wrap[h] = (m_phase[h] == 7 && p == 0);
                    m_phase[h] = p;
                end else begin
                    m_es[h] = 1; m_phase[h] = p; m_mode[h] = 2;
                end
            end else begin
                if (p < 0) m_ec[h] = 1;
                else begin m_phase[h] = p; m_mode[h] = 1; end
            end
            if (cl) begin
                m_revs[h] = 0; m_cnt[h] = 0; m_st[h] = 0;
            end else begin
                if (m_wrap[h] && m_revs[h] < REV_MAX) m_revs[h]++;
                if (m_ec[h] || m_es[h]) begin
                    m_st[h] = 1;
                    if (m_cnt[h] < ERR_MAX) m_cnt[h]++;
                end
            end
        end
    endtask

    function automatic logic [21:0] expect_vec(input int h);
        return {2'(m_mode[h]), 3'(m_phase[h]), m_valid[h], m_wrap[h], 8'(m_revs[h]),
                m_ec[h], m_es[h], m_st[h], 4'(m_cnt[h])};
    endfunction

    // driver: inputs change on the falling edge, outputs are looked at 1 ns after the rising edge
    task automatic cycle(input logic [3:0] c, input logic s, input logic cl);
        @(negedge clk);
        q = c; srst = s; clr = cl;
        @(posedge clk);
        model_step(c, s, cl);
        exp_q.push_back({expect_vec(1), expect_vec(0)});
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs_n !== 22'h0) begin failures++; $display("FAIL reset_n got=%h exp=%h", obs_n, 22'h0); end
        checks++;
        if (obs_h !== 22'h0) begin failures++; $display("FAIL reset_h got=%h exp=%h", obs_h, 22'h0); end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [43:0] e;
        int wraps, last;
        wraps = 0; last = -1; up_k = 0;
        for (int i = 0; i < 41; i++) begin
            cycle(codes[up_k], 1'b1, 1'b0);
            up_k = (up_k + 1) % 8;
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL free_run cyc=%0d got=%h exp=%h", i, {obs_h, obs_n}, e); end
            if (i < 2) begin
                checks++;
                if (n_valid !== (i == 1)) begin failures++; $display("FAIL free_run_valid cyc=%0d got=%b exp=%b", i, n_valid, i == 1); end
            end
            if (n_wrap === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != 8) begin failures++; $display("FAIL wrap_spacing got=%0d exp=8", i - last); end
                end
                last = i; wraps++;
            end
        end
        checks++;
        if (wraps != 5) begin failures++; $display("FAIL wrap_count got=%0d exp=5", wraps); end
        checks++;
        if (n_revs !== 8'd5 || n_cnt !== 4'd0) begin failures++; $display("FAIL free_run_revs got=%0d/%0d exp=5/0", n_revs, n_cnt); end
    endtask

    task automatic test_code_err();
        logic [43:0] e;
        logic [3:0] bad;
        cycle(codes[up_k], 1'b1, 1'b1);
        up_k = (up_k + 1) % 8;
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL code_err_clr got=%h exp=%h", {obs_h, obs_n}, e); end
        do bad = 4'($urandom_range(0, 15)); while (find_phase(bad) >= 0);
        cycle(bad, 1'b1, 1'b0);
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL code_err got=%h exp=%h", {obs_h, obs_n}, e); end
        checks++;
        if ({n_ec, n_es, n_st, n_cnt, n_state} !== {3'b101, 4'd1, 2'd2})
            begin failures++; $display("FAIL code_err_flags got=%b exp=%b", {n_ec, n_es, n_st, n_cnt, n_state}, {3'b101, 4'd1, 2'd2}); end
        for (int i = 0; i < 17; i++) begin
            cycle(codes[up_k], 1'b1, 1'b0);
            up_k = (up_k + 1) % 8;
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL code_err_resume cyc=%0d got=%h exp=%h", i, {obs_h, obs_n}, e); end
            if (i == 0) begin
                checks++;
                if (n_state !== 2'd1 || n_valid !== 1'b0 || n_ec !== 1'b0)
                    begin failures++; $display("FAIL relock got=%0d/%b exp=1/0", n_state, n_valid); end
            end
        end
        checks++;
        if (n_revs !== 8'd2 || n_cnt !== 4'd1) begin failures++; $display("FAIL code_err_counts got=%0d/%0d exp=2/1", n_revs, n_cnt); end
    endtask

    task automatic test_step_err();
        logic [43:0] e;
        int want;
        cycle(codes[up_k], 1'b0, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL step_err_prep got=%h exp=%h", {obs_h, obs_n}, e); end
        for (int r = 0; r < 20; r++) begin
            for (int j = 0; j < 4; j++) begin
                cycle(codes[j == 3 ? 4 : j], 1'b1, 1'b0);
                e = exp_q.pop_front(); checks++;
                if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL step_err r=%0d j=%0d got=%h exp=%h", r, j, {obs_h, obs_n}, e); end
            end
            want = (r + 1 > 15) ? 15 : r + 1;
            checks++;
            if (n_es !== 1'b1 || n_ec !== 1'b0 || n_phase !== 3'd4 || n_cnt !== 4'(want))
                begin failures++; $display("FAIL step_err_flags r=%0d got=%b/%0d/%0d exp=1/4/%0d", r, n_es, n_phase, n_cnt, want); end
        end
    endtask

    task automatic test_up_srst();
        logic [43:0] e;
        logic [3:0] drain [5] = '{4'h7, 4'h6, 4'hE, 4'hC, 4'h8};
        for (int j = 0; j < 3; j++) begin
            cycle(codes[j], 1'b1, 1'b0);
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL srst_prep got=%h exp=%h", {obs_h, obs_n}, e); end
        end
        for (int j = 0; j < 5; j++) begin
            cycle(drain[j], 1'b0, 1'b0);
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL srst_drain j=%0d got=%h exp=%h", j, {obs_h, obs_n}, e); end
            checks++;
            if ({n_ec, n_es, n_valid, n_state, n_phase, n_cnt} !== {3'b000, 2'd0, 3'd2, 4'd15})
                begin failures++; $display("FAIL srst_quiet j=%0d got=%b exp=%b", j, {n_ec, n_es, n_valid, n_state, n_phase, n_cnt}, {3'b000, 2'd0, 3'd2, 4'd15}); end
        end
        cycle(codes[0], 1'b1, 1'b0);
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL srst_relock got=%h exp=%h", {obs_h, obs_n}, e); end
        checks++;
        if (n_state !== 2'd1 || n_phase !== 3'd0 || n_es !== 1'b0) begin failures++; $display("FAIL srst_acquire got=%0d/%0d exp=1/0", n_state, n_phase); end
        cycle(codes[1], 1'b1, 1'b0);
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL srst_track got=%h exp=%h", {obs_h, obs_n}, e); end
    endtask

    task automatic test_hold();
        logic [43:0] e;
        logic [3:0] seq [3] = '{4'h3, 4'h3, 4'h7};
        for (int j = 0; j < 3; j++) begin
            cycle(seq[j], 1'b1, 1'b0);
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL hold j=%0d got=%h exp=%h", j, {obs_h, obs_n}, e); end
            if (j == 1) begin
                checks++;
                if (n_es !== 1'b1 || n_state !== 2'd2) begin failures++; $display("FAIL hold_strict got=%b/%0d exp=1/2", n_es, n_state); end
                checks++;
                if (h_es !== 1'b0 || h_valid !== 1'b1 || h_state !== 2'd1) begin failures++; $display("FAIL hold_allowed got=%b/%b/%0d exp=0/1/1", h_es, h_valid, h_state); end
            end
        end
        up_k = 4;
    endtask

    task automatic test_clr_wrap();
        logic [43:0] e;
        int guard;
        cycle(4'h6, 1'b1, 1'b1);
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL clr_vs_err got=%h exp=%h", {obs_h, obs_n}, e); end
        checks++;
        if (n_ec !== 1'b1 || n_st !== 1'b0 || n_cnt !== 4'd0) begin failures++; $display("FAIL clr_wins got=%b/%b/%0d exp=1/0/0", n_ec, n_st, n_cnt); end
        cycle(4'h5, 1'b1, 1'b0);
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL sticky_set got=%h exp=%h", {obs_h, obs_n}, e); end
        guard = 0;
        while (!(m_revs[0] == REV_MAX && m_phase[0] == 7 && m_mode[0] == 1) && guard < 3000) begin
            cycle(codes[up_k], 1'b1, 1'b0);
            up_k = (up_k + 1) % 8;
            guard++;
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL rev_run cyc=%0d got=%h exp=%h", guard, {obs_h, obs_n}, e); end
        end
        checks++;
        if (guard >= 3000) begin failures++; $display("FAIL rev_run_budget got=%0d exp=<3000", guard); end
        for (int j = 0; j < 8; j++) begin
            cycle(codes[up_k], 1'b1, 1'b0);
            up_k = (up_k + 1) % 8;
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL rev_sat j=%0d got=%h exp=%h", j, {obs_h, obs_n}, e); end
        end
        checks++;
        if (n_revs !== 8'd255 || n_st !== 1'b1) begin failures++; $display("FAIL rev_saturate got=%0d/%b exp=255/1", n_revs, n_st); end
        cycle(codes[up_k], 1'b1, 1'b1);
        up_k = (up_k + 1) % 8;
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL clr_wrap got=%h exp=%h", {obs_h, obs_n}, e); end
        checks++;
        if ({n_wrap, n_revs, n_st, n_state} !== {1'b1, 8'd0, 1'b0, 2'd1})
            begin failures++; $display("FAIL clr_wrap_flags got=%b exp=%b", {n_wrap, n_revs, n_st, n_state}, {1'b1, 8'd0, 1'b0, 2'd1}); end
    endtask

    task automatic test_async_reset();
        logic [43:0] e;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({obs_h, obs_n} !== 44'h0) begin failures++; $display("FAIL async_reset got=%h exp=0", {obs_h, obs_n}); end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        up_k = 5;
        cycle(codes[up_k], 1'b1, 1'b0);
        up_k = (up_k + 1) % 8;
        e = exp_q.pop_front(); checks++;
        if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL async_reacquire got=%h exp=%h", {obs_h, obs_n}, e); end
        checks++;
        if (n_state !== 2'd1 || n_phase !== 3'd5 || n_es !== 1'b0 || n_valid !== 1'b0)
            begin failures++; $display("FAIL async_acquire got=%0d/%0d/%b exp=1/5/0", n_state, n_phase, n_es); end
    endtask

    task automatic test_random();
        logic [43:0] e;
        logic [3:0] c;
        int r;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) c = 4'($urandom_range(0, 15));
            else if (r < 9) c = codes[(up_k + $urandom_range(1, 6)) % 8];
            else if (r < 13) c = codes[(up_k + 7) % 8];
            else begin c = codes[up_k]; up_k = (up_k + 1) % 8; end
            cycle(c, $urandom_range(0, 99) >= 4, $urandom_range(0, 49) == 0);
            e = exp_q.pop_front(); checks++;
            if ({obs_h, obs_n} !== e) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, {obs_h, obs_n}, e); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_code_err();
        test_step_err();
        test_up_srst();
        test_hold();
        test_clr_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "time limit reached");
    end

endmodule
